// File: rtl/pc_sequencer.sv
// Fetch-PC generator: owns the PC register, resolves execute-stage redirects, stall and halt.
// Latency: redirect in cycle N -> pc=target and flush=1 in N+1. Optional MISALIGN_TRAP_EN traps misaligned targets.
module pc_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              STEP     = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_jr,
    input  logic [1:0]      ex_cond,
    input  logic [PC_W-1:0] ex_rs,
    input  logic [PC_W-1:0] ex_pc_inc,
    input  logic [PC_W-1:0] ex_imm,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc,
    output logic            fetch_valid,
    output logic            flush,
    output logic            halted,
    output logic            misalign
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              cond_met;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_seq;

`ifdef MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic              target_misaligned;
`endif

    assign pc_seq = pc_q + PC_W'(STEP);

    always_comb begin
        cond_met = 1'b0;
        case (ex_cond)
            2'b00:   cond_met = (ex_rs == '0);
            2'b01:   cond_met = (ex_rs != '0);
            2'b10:   cond_met = ex_rs[PC_W-1];
            default: cond_met = ~ex_rs[PC_W-1];
        endcase
    end

    // A jump takes precedence over a branch flagged in the same instruction.
    assign taken  = ex_valid & (ex_jump | (ex_branch & cond_met));
    assign target = (ex_jump & ex_jr) ? (ex_rs + ex_imm) : (ex_pc_inc + ex_imm);

`ifdef MISALIGN_TRAP_EN
    assign target_misaligned = ((32'(target) % 32'(STEP)) != 32'd0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    // Any redirect presented alongside halt is dropped.
                    state_d = ST_HALT;
                end else if (taken) begin
`ifdef MISALIGN_TRAP_EN
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                        flush_d    = 1'b1;
                    end else begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end
`else
                    pc_d    = target;
                    flush_d = 1'b1;
`endif
                end else if (!stall) begin
                    pc_d = pc_seq;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign pc          = pc_q;
    assign pc_inc      = pc_seq;
    assign fetch_valid = (state_q == ST_RUN) & ~stall;
    assign flush       = flush_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: table of single-cycle vectors plus hand sequences
// for stall visibility, asynchronous reset mid-redirect and the misaligned-target case.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall, halt, ex_valid, ex_branch, ex_jump, ex_jr;
    logic [1:0]  ex_cond;
    logic [15:0] ex_rs, ex_pc_inc, ex_imm;
    logic [15:0] pc, pc_inc;
    logic        fetch_valid, flush, halted, misalign;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .halt        (halt),
        .ex_valid    (ex_valid),
        .ex_branch   (ex_branch),
        .ex_jump     (ex_jump),
        .ex_jr       (ex_jr),
        .ex_cond     (ex_cond),
        .ex_rs       (ex_rs),
        .ex_pc_inc   (ex_pc_inc),
        .ex_imm      (ex_imm),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .halted      (halted),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        halt;
        logic        valid;
        logic        branch;
        logic        jump;
        logic        jr;
        logic [1:0]  cond;
        logic [15:0] rs;
        logic [15:0] pinc;
        logic [15:0] imm;
        logic [15:0] exp_pc;
        logic        exp_fv;
        logic        exp_flush;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_jr = 0;
        ex_cond = 2'b00; ex_rs = 16'h0; ex_pc_inc = 16'h0; ex_imm = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Fields: stall halt valid branch jump jr cond rs pc_inc imm | pc fv flush halted
    function automatic vec_t mk(input logic st, input logic hl, input logic v, input logic b,
                                input logic j, input logic r, input logic [1:0] c,
                                input logic [15:0] rs, input logic [15:0] pi, input logic [15:0] im,
                                input logic [15:0] epc, input logic efv, input logic efl,
                                input logic eh);
        vec_t t;
        t.stall = st; t.halt = hl; t.valid = v; t.branch = b; t.jump = j; t.jr = r;
        t.cond = c; t.rs = rs; t.pinc = pi; t.imm = im;
        t.exp_pc = epc; t.exp_fv = efv; t.exp_flush = efl; t.exp_halted = eh;
        return t;
    endfunction

    initial begin
        vecs[0]  = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0000,1,0,0); // BOOT->RUN
        vecs[1]  = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0002,1,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0004,1,0,0);
        vecs[3]  = mk(0,0,1,1,0,0,2'b00,16'h0000,16'h0010,16'hFFF0, 16'h0000,1,1,0); // BEQZ taken
        vecs[4]  = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0002,1,0,0);
        vecs[5]  = mk(0,0,1,1,0,0,2'b00,16'h0001,16'h0010,16'hFFF0, 16'h0004,1,0,0); // BEQZ not
        vecs[6]  = mk(0,0,1,1,0,0,2'b10,16'h8000,16'h0100,16'h0020, 16'h0120,1,1,0); // BLTZ taken
        vecs[7]  = mk(0,0,1,1,0,0,2'b11,16'h8000,16'h0100,16'h0020, 16'h0122,1,0,0); // BGEZ not
        vecs[8]  = mk(0,0,1,1,0,0,2'b10,16'h7FFF,16'h0100,16'h0020, 16'h0124,1,0,0); // BLTZ not
        vecs[9]  = mk(0,0,1,1,0,0,2'b11,16'h7FFF,16'h0200,16'h0010, 16'h0210,1,1,0); // BGEZ taken
        vecs[10] = mk(0,0,1,1,0,0,2'b01,16'h0005,16'h0300,16'hFFFE, 16'h02FE,1,1,0); // BNEZ b2b
        vecs[11] = mk(0,0,0,0,1,0,2'b00,16'h0000,16'h0500,16'h0000, 16'h0300,1,0,0); // invalid
        vecs[12] = mk(1,0,1,0,1,1,2'b00,16'h1234,16'h0000,16'h0004, 16'h1238,1,1,0); // JR/stall
        vecs[13] = mk(1,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h1238,1,0,0);
        vecs[14] = mk(1,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h1238,1,0,0);
        vecs[15] = mk(0,0,1,0,1,0,2'b00,16'h0000,16'hFFF0,16'h000E, 16'hFFFE,1,1,0); // J
        vecs[16] = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0000,1,0,0); // wrap
        vecs[17] = mk(0,0,1,1,1,0,2'b00,16'h0005,16'h0040,16'h0004, 16'h0044,1,1,0); // jump wins
        vecs[18] = mk(0,1,1,0,1,0,2'b00,16'h0000,16'h0500,16'h0000, 16'h0044,0,0,1); // halt+jump
        vecs[19] = mk(0,0,0,0,0,0,2'b00,16'h0000,16'h0000,16'h0000, 16'h0044,0,0,1);
        vecs[20] = mk(0,0,1,0,1,0,2'b00,16'h0000,16'h0600,16'h0000, 16'h0044,0,0,1);

        idle_inputs();
        rst_n = 0;
        #2;
        chk("async_reset_pc", 32'(pc), 32'h0);
        do_reset();
        chk("boot_pc", 32'(pc), 32'h0);
        chk("boot_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("boot_flush", 32'(flush), 32'h0);
        chk("boot_halted", 32'(halted), 32'h0);
        chk("boot_misalign", 32'(misalign), 32'h0);
        chk("boot_pc_inc", 32'(pc_inc), 32'h2);

        for (int i = 0; i < 21; i++) begin
            stall = vecs[i].stall; halt = vecs[i].halt; ex_valid = vecs[i].valid;
            ex_branch = vecs[i].branch; ex_jump = vecs[i].jump; ex_jr = vecs[i].jr;
            ex_cond = vecs[i].cond; ex_rs = vecs[i].rs; ex_pc_inc = vecs[i].pinc;
            ex_imm = vecs[i].imm;
            tick();
            idle_inputs();
            #1;
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].exp_fv));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
            chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'h0);
        end

        // Stall gates fetch_valid combinationally while running.
        do_reset();
        tick();
        stall = 1;
        #1;
        chk("stall_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("stall_pc_inc", 32'(pc_inc), 32'h2);
        stall = 0;
        #1;
        chk("unstall_fetch_valid", 32'(fetch_valid), 32'h1);

        // Reset mid-redirect: pending target lost, reset values return immediately.
        ex_valid = 1; ex_jump = 1; ex_pc_inc = 16'h0800; ex_imm = 16'h0000;
        tick();
        chk("redir_pc", 32'(pc), 32'h0800);
        chk("redir_flush", 32'(flush), 32'h1);
        ex_pc_inc = 16'h0900;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_flush", 32'(flush), 32'h0);
        chk("midrst_fetch_valid", 32'(fetch_valid), 32'h0);
        idle_inputs();
        tick();
        rst_n = 1;
        tick();
        tick();
        chk("midrst_resume_pc", 32'(pc), 32'h2);

        // Misaligned JR target 0x1001 presented while pc=0x0002.
        do_reset();
        tick();
        tick();
        ex_valid = 1; ex_jump = 1; ex_jr = 1; ex_rs = 16'h1000; ex_imm = 16'h0001;
        tick();
        idle_inputs();
        #1;
`ifdef MISALIGN_TRAP_EN
        chk("mis_pc", 32'(pc), 32'h2);
        chk("mis_misalign", 32'(misalign), 32'h1);
        chk("mis_halted", 32'(halted), 32'h1);
        chk("mis_flush", 32'(flush), 32'h1);
        tick();
        chk("mis_flush_drop", 32'(flush), 32'h0);
        chk("mis_sticky", 32'(misalign), 32'h1);
        chk("mis_pc_frozen", 32'(pc), 32'h2);
`else
        chk("mis_pc", 32'(pc), 32'h1001);
        chk("mis_misalign", 32'(misalign), 32'h0);
        chk("mis_halted", 32'(halted), 32'h0);
        chk("mis_flush", 32'(flush), 32'h1);
        tick();
        chk("mis_flush_drop", 32'(flush), 32'h0);
        chk("mis_next_pc", 32'(pc), 32'h1003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
